uart_cmd_decoder: RTL and testbench

Frame decoder that sits directly downstream of the UART receiver. It consumes the receiver's one-cycle `rx_done` strobe and `rx_byte`. It hunts for a sync byte, assembles a fixed 6-byte command frame and verifies an XOR checksum. Good frames are presented on a valid/ready output toward the register/control logic. Frames that are bad, stalled or arrive while the output is still occupied are dropped and flagged.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_frame_timer.sv | 31 +++
 rtl/uart_cmd_decoder.sv | 147 ++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: decoder state encoding, command payload layout,
// default frame marker and the baud divider helper used by the TX/RX blocks.
package uart_pkg;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Frame decoder states, one per expected byte position
  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_OP   = 3'd1,
    S_ADDR = 3'd2,
    S_DHI  = 3'd3,
    S_DLO  = 3'd4,
    S_CSUM = 3'd5
  } dec_state_t;

  // Decoded command payload
  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  addr;
    logic [15:0] data;
  } cmd_t;

  // System clocks per UART bit period
  function automatic int unsigned clks_per_bit(input int unsigned freq,
                                               input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter for the frame decoder.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - holds the counter at zero (byte strobe or idle hunting)
//   expire_c    - combinational: count has reached TIMEOUT_CLKS-1 while not cleared
module uart_frame_timer #(
  parameter int unsigned TIMEOUT_CLKS = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] count;

  assign expire_c = (count == LAST) && !clear;

  // Restarting on expiry keeps the counter from ever wrapping
  always_ff @(posedge clk) begin
    if (reset || clear || expire_c) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Command frame decoder placed after the UART receiver. Hunts for the sync
// byte, collects OP/ADDR/DHI/DLO/CSUM, checks the XOR checksum and presents
// good frames on a valid/ready interface. Bad, stalled or overrun frames are
// dropped with a one-cycle error pulse.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   rx_done, rx_byte      - receiver byte strobe and data
//   cmd_valid, cmd_ready  - output handshake
//   cmd_op, cmd_addr      - opcode and address bytes
//   cmd_data              - {DHI, DLO}
//   err_csum              - pulse: checksum mismatch
//   err_timeout           - pulse: frame abandoned mid-way
//   err_overrun           - pulse: good frame dropped, output occupied
module uart_cmd_decoder
  import uart_pkg::*;
#(
  parameter int unsigned FREQUENCY     = 10_000_000,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned TIMEOUT_BYTES = 4,
  parameter logic [7:0]  SYNC_BYTE     = DEFAULT_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done,
  input  logic [7:0]  rx_byte,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        err_csum,
  output logic        err_timeout,
  output logic        err_overrun
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(FREQUENCY, BAUD_RATE);
  localparam int unsigned TIMEOUT_CLKS = CLKS_PER_BIT * 10 * TIMEOUT_BYTES;

  dec_state_t state_q, state_d;
  logic [7:0] acc_q, acc_d;
  cmd_t       shadow_q, shadow_d;
  cmd_t       cmd_q, cmd_d;
  logic       valid_d;
  logic       err_csum_d, err_timeout_d, err_overrun_d;
  logic       timer_clear_c, timer_expire_c;

  // Timer runs only while a frame is partially received
  assign timer_clear_c = rx_done || (state_q == S_SYNC);

  uart_frame_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear_c),
    .expire_c (timer_expire_c)
  );

  assign cmd_op   = cmd_q.op;
  assign cmd_addr = cmd_q.addr;
  assign cmd_data = cmd_q.data;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_SYNC;
      acc_q       <= '0;
      shadow_q    <= '0;
      cmd_q       <= '0;
      cmd_valid   <= 1'b0;
      err_csum    <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      shadow_q    <= shadow_d;
      cmd_q       <= cmd_d;
      cmd_valid   <= valid_d;
      err_csum    <= err_csum_d;
      err_timeout <= err_timeout_d;
      err_overrun <= err_overrun_d;
    end
  end

  // Next-state, byte capture, checksum verdict and handshake
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    shadow_d      = shadow_q;
    cmd_d         = cmd_q;
    valid_d       = cmd_valid && !cmd_ready;
    err_csum_d    = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;

    if (rx_done) begin
      unique case (state_q)
        S_SYNC: begin
          if (rx_byte == SYNC_BYTE) begin
            acc_d   = '0;
            state_d = S_OP;
          end
        end
        S_OP: begin
          shadow_d.op = rx_byte;
          acc_d       = acc_q ^ rx_byte;
          state_d     = S_ADDR;
        end
        S_ADDR: begin
          shadow_d.addr = rx_byte;
          acc_d         = acc_q ^ rx_byte;
          state_d       = S_DHI;
        end
        S_DHI: begin
          shadow_d.data[15:8] = rx_byte;
          acc_d               = acc_q ^ rx_byte;
          state_d             = S_DLO;
        end
        S_DLO: begin
          shadow_d.data[7:0] = rx_byte;
          acc_d              = acc_q ^ rx_byte;
          state_d            = S_CSUM;
        end
        S_CSUM: begin
          state_d = S_SYNC;
          if (acc_q != rx_byte) begin
            err_csum_d = 1'b1;
          end else if (!cmd_valid || cmd_ready) begin
            // Output slot is free, or being emptied this very cycle
            cmd_d   = shadow_q;
            valid_d = 1'b1;
          end else begin
            err_overrun_d = 1'b1;
          end
        end
        default: begin
          state_d = S_SYNC;
        end
      endcase
    end else if (timer_expire_c) begin
      state_d       = S_SYNC;
      err_timeout_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed self-checking bench for uart_cmd_decoder (TIMEOUT_CLKS = 200).
module tb_uart_cmd_decoder;

  logic        clk;
  logic        reset;
  logic        rx_done;
  logic [7:0]  rx_byte;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        err_csum;
  logic        err_timeout;
  logic        err_overrun;

  int checks = 0;
  int errors = 0;
  int n_csum = 0;
  int n_to   = 0;
  int n_ovr  = 0;

  uart_cmd_decoder #(
    .FREQUENCY     (1_000_000),
    .BAUD_RATE     (100_000),
    .TIMEOUT_BYTES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_done     (rx_done),
    .rx_byte     (rx_byte),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .err_csum    (err_csum),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every error pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (err_csum === 1'b1)    n_csum++;
    if (err_timeout === 1'b1) n_to++;
    if (err_overrun === 1'b1) n_ovr++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_done = 1'b1;
    rx_byte = b;
    tick();
    rx_done = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic send_good1();
    send(8'hA5); send(8'h01); send(8'h10); send(8'hBE); send(8'hEF); send(8'h40);
  endtask

  task automatic check_cmd(input string tag, input logic [7:0] op, input logic [7:0] addr,
                           input logic [15:0] data);
    check({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    check({tag, "_op"},    32'(cmd_op),    32'(op));
    check({tag, "_addr"},  32'(cmd_addr),  32'(addr));
    check({tag, "_data"},  32'(cmd_data),  32'(data));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(cmd_valid),   32'd0);
    check({tag, "_op"},    32'(cmd_op),      32'd0);
    check({tag, "_addr"},  32'(cmd_addr),    32'd0);
    check({tag, "_data"},  32'(cmd_data),    32'd0);
    check({tag, "_ecs"},   32'(err_csum),    32'd0);
    check({tag, "_eto"},   32'(err_timeout), 32'd0);
    check({tag, "_eov"},   32'(err_overrun), 32'd0);
  endtask

  initial begin
    int base_cs, base_to, base_ov;
    reset     = 1'b1;
    rx_done   = 1'b0;
    rx_byte   = 8'h00;
    cmd_ready = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Good frame
    cmd_ready = 1'b1;
    send(8'hA5); send(8'h01); send(8'h10); send(8'hBE); send(8'hEF);
    check("good_pre_valid", 32'(cmd_valid), 32'd0);
    send(8'h40);
    check_cmd("good", 8'h01, 8'h10, 16'hBEEF);
    tick();
    check("good_accepted", 32'(cmd_valid), 32'd0);
    check("good_no_csum", 32'(n_csum), 32'd0);
    check("good_no_ovr", 32'(n_ovr), 32'd0);
    check("good_no_to", 32'(n_to), 32'd0);

    // Junk hunt then bad checksum
    send(8'h33);
    send(8'hA5); send(8'h01); send(8'h10); send(8'hBE); send(8'hEF); send(8'h41);
    check("bad_err_csum", 32'(err_csum), 32'd1);
    check("bad_valid", 32'(cmd_valid), 32'd0);
    tick();
    check("bad_err_csum_pulse", 32'(err_csum), 32'd0);
    send(8'hA5); send(8'h02); send(8'h20); send(8'h12); send(8'h34); send(8'h04);
    check_cmd("after_bad", 8'h02, 8'h20, 16'h1234);
    tick();
    check("bad_csum_count", 32'(n_csum), 32'd1);
    check("bad_no_to", 32'(n_to), 32'd0);

    // Overrun: second frame dropped while the first is held
    cmd_ready = 1'b0;
    send_good1();
    check_cmd("ovr_first", 8'h01, 8'h10, 16'hBEEF);
    send(8'hA5); send(8'h02); send(8'h20); send(8'h12); send(8'h34); send(8'h04);
    check("ovr_pulse", 32'(err_overrun), 32'd1);
    check_cmd("ovr_held", 8'h01, 8'h10, 16'hBEEF);
    tick();
    check("ovr_pulse_end", 32'(err_overrun), 32'd0);
    cmd_ready = 1'b1;
    check_cmd("ovr_xfer", 8'h01, 8'h10, 16'hBEEF);
    tick();
    check("ovr_cleared", 32'(cmd_valid), 32'd0);
    check("ovr_count", 32'(n_ovr), 32'd1);

    // Acceptance and new load in the same cycle
    cmd_ready = 1'b0;
    send_good1();
    send(8'hA5); send(8'h02); send(8'h20); send(8'h12); send(8'h34);
    cmd_ready = 1'b1;
    send(8'h04);
    check_cmd("same_cycle", 8'h02, 8'h20, 16'h1234);
    check("same_cycle_no_ovr", 32'(n_ovr), 32'd1);
    tick();
    check("same_cycle_cleared", 32'(cmd_valid), 32'd0);

    // Timeout after 200 idle clocks
    send(8'hA5); send(8'h01);
    repeat (199) tick();
    check("to_not_yet", 32'(err_timeout), 32'd0);
    tick();
    check("to_pulse", 32'(err_timeout), 32'd1);
    tick();
    check("to_pulse_end", 32'(err_timeout), 32'd0);
    send_good1();
    check_cmd("after_to", 8'h01, 8'h10, 16'hBEEF);
    tick();

    // Byte arriving exactly at count 199 wins over expiry
    send(8'hA5); send(8'h01);
    repeat (199) tick();
    send(8'h10);
    check("tie_no_to", 32'(err_timeout), 32'd0);
    send(8'hBE); send(8'hEF); send(8'h40);
    check_cmd("tie", 8'h01, 8'h10, 16'hBEEF);
    tick();
    check("tie_to_count", 32'(n_to), 32'd1);

    // Reset mid-frame, with a command held at the output
    cmd_ready = 1'b0;
    send(8'hA5); send(8'h02); send(8'h20); send(8'h12); send(8'h34); send(8'h04);
    check_cmd("pre_reset", 8'h02, 8'h20, 16'h1234);
    send(8'hA5); send(8'h01); send(8'h10);
    reset = 1'b1;
    tick();
    check_all_zero("in_reset");
    reset = 1'b0;
    base_cs = n_csum;
    base_to = n_to;
    base_ov = n_ovr;
    send(8'hBE); send(8'hEF); send(8'h40);
    tick();
    check("rst_no_valid", 32'(cmd_valid), 32'd0);
    check("rst_no_csum", 32'(n_csum - base_cs), 32'd0);
    check("rst_no_to", 32'(n_to - base_to), 32'd0);
    check("rst_no_ovr", 32'(n_ovr - base_ov), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
